nv_ram_fifo_ctrl_64x512: RTL and testbench

//  Streaming FIFO controller that owns both ports of an external 64x512 dual-port RAM.
//  The RAM has a registered read address: ra is latched when re=1, and dout=M[ra_d] is

---
 rtl/nv_ram_fifo_pkg.sv | 11 +
 rtl/nv_ram_fifo_obuf.sv | 46 ++++
 rtl/nv_ram_fifo_ctrl_64x512.sv | 87 ++++++++
 tb/tb_nv_ram_fifo_ctrl_64x512.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/nv_ram_fifo_pkg.sv
// nv_ram_fifo_pkg: shared sizing constants and helpers for the 64x512 RAM-backed FIFO controller.
package nv_ram_fifo_pkg;
    localparam int NV_RAMF_DEPTH = 64;
    localparam int NV_RAMF_AW    = 6;
    localparam int NV_RAMF_DW    = 512;

    // Bits needed to hold an occupancy of 0..depth+2 (RAM plus the two-entry output buffer).
    function automatic int nv_ram_cnt_w(input int depth);
        return $clog2(depth + 3);
    endfunction
endpackage

// File: rtl/nv_ram_fifo_obuf.sv
// nv_ram_fifo_obuf: 2-entry in-order skid buffer that absorbs the RAM read latency.
module nv_ram_fifo_obuf
    import nv_ram_fifo_pkg::*;
#(
    parameter int DW = NV_RAMF_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_vld,
    input  logic [DW-1:0] in_pd,
    input  logic          out_rdy,
    output logic          out_vld,
    output logic [DW-1:0] out_pd,
    output logic [1:0]    cnt
);
    logic [DW-1:0] head_q, head_d, tail_q, tail_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          pop;

    always_comb begin
        pop     = out_rdy && cnt_q != 2'd0;
        head_d  = (pop && cnt_q == 2'd2) ? tail_q :
                  (in_vld && (cnt_q == 2'd0 || (pop && cnt_q == 2'd1))) ? in_pd : head_q;
        tail_d  = (in_vld && ((cnt_q == 2'd1 && !pop) || (cnt_q == 2'd2 && pop))) ? in_pd : tail_q;
        cnt_d   = cnt_q + {1'b0, in_vld} - {1'b0, pop};
        out_vld = cnt_q != 2'd0;
        out_pd  = head_q;
        cnt     = cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) assert (!(in_vld && cnt_q == 2'd2 && !pop));
    end
endmodule

// File: rtl/nv_ram_fifo_ctrl_64x512.sv
// nv_ram_fifo_ctrl_64x512: streaming FIFO controller owning both ports of an external
// dual-port RAM with registered read address; a 2-entry output buffer hides read latency.
module nv_ram_fifo_ctrl_64x512
    import nv_ram_fifo_pkg::*;
#(
    parameter int DEPTH = NV_RAMF_DEPTH,
    parameter int AW    = NV_RAMF_AW,
    parameter int DW    = NV_RAMF_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_pvld,
    output logic          wr_prdy,
    input  logic [DW-1:0] wr_pd,
    output logic          rd_pvld,
    input  logic          rd_prdy,
    output logic [DW-1:0] rd_pd,
    output logic [AW-1:0] ram_wa,
    output logic          ram_we,
    output logic [DW-1:0] ram_di,
    output logic [AW-1:0] ram_ra,
    output logic          ram_re,
    input  logic [DW-1:0] ram_dout,
    output logic [AW:0]   fifo_count
);
    localparam int CW = nv_ram_cnt_w(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] ram_cnt_q, ram_cnt_d;
    logic          inflight_q, inflight_d;
    logic [1:0]    obuf_cnt;
    logic          obuf_vld, push_fire, pop_fire;
    logic [2:0]    pend;

    always_comb begin
        wr_prdy    = !rst && ram_cnt_q < CW'(DEPTH);
        push_fire  = wr_pvld && wr_prdy;
        rd_pvld    = !rst && obuf_vld;
        pop_fire   = rd_pvld && rd_prdy;
        pend       = {2'b0, inflight_q} + {1'b0, obuf_cnt};
        // A pop this cycle frees a buffer slot in time for the read issued now.
        ram_re     = !rst && ram_cnt_q != '0 && pend < 3'd2 + {2'b0, pop_fire};
        ram_we     = push_fire;
        ram_wa     = wr_ptr_q;
        ram_di     = wr_pd;
        ram_ra     = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q + AW'(push_fire);
        rd_ptr_d   = rd_ptr_q + AW'(ram_re);
        ram_cnt_d  = ram_cnt_q + CW'(push_fire) - CW'(ram_re);
        inflight_d = ram_re;
        fifo_count = rst ? '0 : (AW+1)'(ram_cnt_q + CW'(inflight_q) + CW'(obuf_cnt));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ram_cnt_q  <= '0;
            inflight_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ram_cnt_q  <= ram_cnt_d;
            inflight_q <= inflight_d;
        end
    end

    nv_ram_fifo_obuf #(.DW(DW)) u_obuf (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (inflight_q),
        .in_pd   (ram_dout),
        .out_rdy (rd_prdy),
        .out_vld (obuf_vld),
        .out_pd  (rd_pd),
        .cnt     (obuf_cnt)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!ram_we || wr_prdy);
            assert (!ram_re || ram_cnt_q != '0);
            assert (pend <= 3'd2);
            assert (fifo_count <= (AW+1)'(DEPTH + 2));
        end
    end
endmodule

// File: tb/tb_nv_ram_fifo_ctrl_64x512.sv
// tb_nv_ram_fifo_ctrl_64x512: directed and random checks against a queue-based reference model.
module tb_nv_ram_fifo_ctrl_64x512;
    localparam int DW = 512;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_pvld, wr_prdy, rd_pvld, rd_prdy, ram_we, ram_re;
    logic [DW-1:0] wr_pd, rd_pd, ram_di, ram_dout;
    logic [AW-1:0] ram_wa, ram_ra;
    logic [AW:0]   fifo_count;

    int total = 0;
    int bad = 0;

    nv_ram_fifo_ctrl_64x512 dut (
        .clk        (clk),
        .rst        (rst),
        .wr_pvld    (wr_pvld),
        .wr_prdy    (wr_prdy),
        .wr_pd      (wr_pd),
        .rd_pvld    (rd_pvld),
        .rd_prdy    (rd_prdy),
        .rd_pd      (rd_pd),
        .ram_wa     (ram_wa),
        .ram_we     (ram_we),
        .ram_di     (ram_di),
        .ram_ra     (ram_ra),
        .ram_re     (ram_re),
        .ram_dout   (ram_dout),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    // External RAM: registered read address, data readable the cycle after the strobe.
    logic [DW-1:0] mem [64];
    logic [AW-1:0] ra_q;
    always @(posedge clk) begin
        if (ram_we) mem[ram_wa] <= ram_di;
        if (ram_re) ra_q <= ram_ra;
    end
    assign ram_dout = mem[ra_q];

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: queue of accepted words plus running push/read-issue totals.
    logic [DW-1:0] q[$];
    int wn = 0;
    int rn = 0;
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            wn = 0;
            rn = 0;
        end else begin
            chk("occupancy", DW'(fifo_count), DW'(q.size()));
            if (q.size() < 64) chk("ready_below_full", DW'(wr_prdy), 1);
            if (q.size() == 66) chk("ready_at_full", DW'(wr_prdy), 0);
            if (q.size() == 0) chk("idle_when_empty", DW'({rd_pvld, ram_re}), 0);
            chk("we_is_push", DW'(ram_we), DW'(wr_pvld && wr_prdy));
            if (ram_re) begin
                chk("read_addr", DW'(ram_ra), DW'(rn % 64));
                rn++;
            end
            if (rd_pvld && rd_prdy) begin
                if (q.size() == 0) chk("pop_from_empty", DW'(1), 0);
                else chk("pop_data", rd_pd, q.pop_front());
            end
            if (ram_we) begin
                chk("write_addr", DW'(ram_wa), DW'(wn % 64));
                chk("write_data", ram_di, wr_pd);
                q.push_back(wr_pd);
                wn++;
            end
        end
    end

    initial begin
        int n;
        int pops;
        int cyc;
        // T1 reset, with push attempted while held
        rst = 1'b1; wr_pvld = 1'b1; rd_prdy = 1'b1; wr_pd = rnd();
        repeat (3) begin
            @(negedge clk);
            chk("t1_rst_vld", DW'(rd_pvld), 0);
            chk("t1_rst_prdy", DW'(wr_prdy), 0);
            chk("t1_rst_we_re", DW'({ram_we, ram_re}), 0);
            chk("t1_rst_cnt", DW'(fifo_count), 0);
        end
        tick(); rst = 1'b0; wr_pvld = 1'b0;
        @(negedge clk);
        chk("t1_prdy", DW'(wr_prdy), 1);
        chk("t1_vld", DW'(rd_pvld), 0);
        chk("t1_cnt", DW'(fifo_count), 0);
        chk("t1_re", DW'(ram_re), 0);
        // T2 single word latency
        tick(); wr_pvld = 1'b1; wr_pd = {64{8'hA5}};
        @(negedge clk); chk("t2_we", DW'(ram_we), 1);
        tick(); wr_pvld = 1'b0;
        @(negedge clk); chk("t2_vld_c1", DW'(rd_pvld), 0);
        tick();
        @(negedge clk); chk("t2_vld_c2", DW'(rd_pvld), 0);
        tick();
        @(negedge clk); chk("t2_vld_c3", DW'(rd_pvld), 1); chk("t2_data", rd_pd, {64{8'hA5}});
        tick();
        @(negedge clk); chk("t2_vld_after", DW'(rd_pvld), 0); chk("t2_cnt_after", DW'(fifo_count), 0);
        // T3 fill to capacity, then drain in order
        tick(); rd_prdy = 1'b0; wr_pvld = 1'b1; n = 0;
        repeat (75) begin
            wr_pd = DW'(n);
            @(negedge clk);
            if (wr_prdy) n++;
            tick();
        end
        wr_pvld = 1'b0;
        @(negedge clk);
        chk("t3_accepted", DW'(n), 66);
        chk("t3_full_prdy", DW'(wr_prdy), 0);
        chk("t3_full_cnt", DW'(fifo_count), 66);
        tick(); rd_prdy = 1'b1;
        for (int i = 0; i < 66; i++) begin
            @(negedge clk);
            chk("t3_drain_vld", DW'(rd_pvld), 1);
            chk("t3_drain_data", rd_pd, DW'(i));
            tick();
        end
        @(negedge clk); chk("t3_empty_vld", DW'(rd_pvld), 0); chk("t3_empty_cnt", DW'(fifo_count), 0);
        // T4 sustained streaming across pointer wraps
        tick();
        for (int c = 0; c < 203; c++) begin
            wr_pvld = c < 200;
            wr_pd = rnd();
            @(negedge clk);
            if (c >= 3) chk("t4_no_bubble", DW'(rd_pvld), 1);
            chk("t4_cnt_le3", DW'(fifo_count <= 3), 1);
            tick();
        end
        wr_pvld = 1'b0;
        @(negedge clk); chk("t4_drained", DW'(fifo_count), 0);
        // T5 random backpressure on both sides
        tick(); n = 0; cyc = 0;
        while (n < 5000 && cyc < 30000) begin
            wr_pvld = $urandom_range(1);
            rd_prdy = $urandom_range(1);
            wr_pd = rnd();
            @(negedge clk);
            if (wr_pvld && wr_prdy) n++;
            cyc++;
            tick();
        end
        chk("t5_pushed", DW'(n), 5000);
        wr_pvld = 1'b0; rd_prdy = 1'b1; cyc = 0;
        while (fifo_count != 0 && cyc < 200) begin
            tick();
            cyc++;
        end
        @(negedge clk); chk("t5_drained", DW'(fifo_count), 0);
        // T6 reset with content buffered
        tick(); rd_prdy = 1'b0; wr_pvld = 1'b1;
        repeat (10) begin
            wr_pd = rnd();
            tick();
        end
        wr_pvld = 1'b0;
        tick();
        @(negedge clk); chk("t6_buffered", DW'(fifo_count), 10);
        tick(); rst = 1'b1;
        @(negedge clk); chk("t6_rst_vld", DW'(rd_pvld), 0); chk("t6_rst_cnt", DW'(fifo_count), 0);
        tick(); rst = 1'b0;
        @(negedge clk); chk("t6_post_vld", DW'(rd_pvld), 0); chk("t6_post_cnt", DW'(fifo_count), 0);
        tick(); wr_pvld = 1'b1; wr_pd = DW'(1);
        tick(); wr_pvld = 1'b0; rd_prdy = 1'b1; pops = 0;
        repeat (10) begin
            @(negedge clk);
            if (rd_pvld) begin
                pops++;
                chk("t6_data", rd_pd, DW'(1));
            end
            tick();
        end
        chk("t6_pops", DW'(pops), 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
